// File: rtl/bos_tx_pkg.sv
// Shared constants, FSM state encoding and checksum helper for the UART reply arbiter.
package bos_tx_pkg;

  localparam int         N_SRC_DEF   = 18;
  localparam logic [7:0] PREFIX_BYTE = 8'hDD;
  localparam logic [7:0] MY_ADDR_DEF = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREFIX   = 3'd1,
    ST_SRC_ADDR = 3'd2,
    ST_DST_ADDR = 3'd3,
    ST_LEN      = 3'd4,
    ST_PAYLOAD  = 3'd5,
    ST_CRC      = 3'd6
  } state_e;

  // Packet checksum is a plain modulo-256 sum of payload bytes.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int N_SRC = 18,
  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_SRC-1:0] gnt,
  output logic [PW-1:0]    idx,
  output logic             valid
);

  function automatic int wrap_add(input int a, input int b);
    return (a + b >= N_SRC) ? (a + b - N_SRC) : (a + b);
  endfunction

  // Scan N_SRC positions starting at ptr; the first hit wins.
  always_comb begin
    gnt   = {N_SRC{1'b0}};
    idx   = {PW{1'b0}};
    valid = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      logic hit_s;
      hit_s = !valid && req[wrap_add(int'(ptr), k)];
      gnt[wrap_add(int'(ptr), k)] = hit_s;
      idx   = hit_s ? PW'(wrap_add(int'(ptr), k)) : idx;
      valid = valid | hit_s;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin framer sharing one UART tx between N_SRC reply FIFOs.
// Optional macro URGENT_SRC0_EN: source 0 pre-empts round-robin in IDLE without moving the pointer.
module uart_tx_arbiter
  import bos_tx_pkg::*;
#(
  parameter int         N_SRC   = N_SRC_DEF,
  parameter logic [7:0] MY_ADDR = MY_ADDR_DEF,
  parameter logic [7:0] PREFIX  = PREFIX_BYTE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRC-1:0]     have_msg_bus,
  input  logic [8*N_SRC-1:0]   len_bus,
  input  logic [8*N_SRC-1:0]   data_bus,
  output logic [N_SRC-1:0]     rd_req_bus,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [N_SRC-1:0]     grant
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [N_SRC-1:0] SRC0_BIT = {{(N_SRC-1){1'b0}}, 1'b1};

  state_e           state_r;
  logic [PW-1:0]    idx_r;
  logic [PW-1:0]    ptr_r;
  logic [7:0]       len_r;
  logic [7:0]       csum_r;
  logic [7:0]       byte_r;

  logic [N_SRC-1:0] arb_req_s;
  logic [N_SRC-1:0] arb_gnt_s;
  logic [N_SRC-1:0] pick_gnt_s;
  logic [PW-1:0]    arb_idx_s;
  logic [PW-1:0]    pick_idx_s;
  logic [PW-1:0]    ptr_after_s;
  logic [PW-1:0]    next_ptr_s;
  logic             arb_valid_s;
  logic             pick_valid_s;
  logic             hs_s;
  logic [7:0]       cur_byte_s;
  logic [7:0]       len_sel_s;

  rr_arbiter #(.N_SRC(N_SRC)) u_rr (
    .req   (arb_req_s),
    .ptr   (ptr_r),
    .gnt   (arb_gnt_s),
    .idx   (arb_idx_s),
    .valid (arb_valid_s)
  );

  // Winner selection and the pointer value to commit at end of packet.
  always_comb begin
    ptr_after_s = (idx_r == PW'(N_SRC - 1)) ? {PW{1'b0}} : idx_r + PW'(1);
`ifdef URGENT_SRC0_EN
    arb_req_s    = have_msg_bus & ~SRC0_BIT;
    pick_valid_s = have_msg_bus[0] | arb_valid_s;
    pick_gnt_s   = have_msg_bus[0] ? SRC0_BIT : arb_gnt_s;
    pick_idx_s   = have_msg_bus[0] ? {PW{1'b0}} : arb_idx_s;
    next_ptr_s   = (idx_r == {PW{1'b0}}) ? ptr_r : ptr_after_s;
`else
    arb_req_s    = have_msg_bus;
    pick_valid_s = arb_valid_s;
    pick_gnt_s   = arb_gnt_s;
    pick_idx_s   = arb_idx_s;
    next_ptr_s   = ptr_after_s;
`endif
  end

  // Source byte lanes and handshake; payload bytes come straight from the show-ahead FIFO head.
  always_comb begin
    hs_s       = tx_valid & tx_ready;
    cur_byte_s = data_bus[8*int'(idx_r) +: 8];
    len_sel_s  = len_bus[8*int'(pick_idx_s) +: 8];
    tx_data    = (state_r == ST_PAYLOAD) ? cur_byte_s : byte_r;
  end

  // Pop strobe coincides with the payload handshake; suppressed while reset is asserted.
  always_comb begin
    rd_req_bus = {N_SRC{1'b0}};
    if (hs_s && (state_r == ST_PAYLOAD) && !rst) begin
      rd_req_bus[idx_r] = 1'b1;
    end else begin
      rd_req_bus = {N_SRC{1'b0}};
    end
  end

  // Packet framing FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      idx_r    <= {PW{1'b0}};
      ptr_r    <= {PW{1'b0}};
      len_r    <= 8'h00;
      csum_r   <= 8'h00;
      byte_r   <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      grant    <= {N_SRC{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            grant    <= pick_gnt_s;
            idx_r    <= pick_idx_s;
            len_r    <= len_sel_s;
            csum_r   <= 8'h00;
            byte_r   <= PREFIX;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state_r  <= ST_PREFIX;
          end
        end
        ST_PREFIX: begin
          if (hs_s) begin
            byte_r  <= MY_ADDR;
            state_r <= ST_SRC_ADDR;
          end
        end
        ST_SRC_ADDR: begin
          if (hs_s) begin
            byte_r  <= 8'(idx_r);
            state_r <= ST_DST_ADDR;
          end
        end
        ST_DST_ADDR: begin
          if (hs_s) begin
            byte_r  <= len_r;
            state_r <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (hs_s) begin
            if (len_r == 8'h00) begin
              byte_r  <= csum_r;
              state_r <= ST_CRC;
            end else begin
              state_r <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (hs_s) begin
            csum_r <= csum_add(csum_r, cur_byte_s);
            len_r  <= len_r - 8'd1;
            if (len_r == 8'd1) begin
              byte_r  <= csum_add(csum_r, cur_byte_s);
              state_r <= ST_CRC;
            end
          end
        end
        ST_CRC: begin
          if (hs_s) begin
            ptr_r    <= next_ptr_s;
            grant    <= {N_SRC{1'b0}};
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            byte_r   <= 8'h00;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          grant    <= {N_SRC{1'b0}};
          byte_r   <= 8'h00;
        end
      endcase
    end
  end

endmodule
